mode_counter: RTL and testbench

Parametrised multi-mode counter that merges the separate up, down, Johnson and ring counters into one block.
- Mode is selected at run time; the block also supports synchronous load and terminal-count reporting.
- An internal tick prescaler removes the need to clock counters from a divided clock. The whole design stays on a single clock domain.
- Sits between board inputs (SW) and the LEDR display in board top-levels; also reusable as a sequencer.

---
 rtl/mode_counter_pkg.sv | 40 ++++
 rtl/tick_prescaler.sv | 28 ++
 rtl/mode_counter.sv | 98 +++++++++
 tb/tb_mode_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mode_counter_pkg.sv
// Shared mode encodings and state-classification helpers for mode_counter.
// Helpers work on 32-bit values masked to the active counter width.
package mode_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP      = 2'b00;
  localparam mode_t MODE_DOWN    = 2'b01;
  localparam mode_t MODE_JOHNSON = 2'b10;
  localparam mode_t MODE_RING    = 2'b11;

  function automatic logic [31:0] width_mask(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

  function automatic logic [31:0] seed(input mode_t mode, input int unsigned width);
    case (mode)
      MODE_DOWN: return width_mask(width);
      MODE_RING: return 32'd1;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [31:0] v, input int unsigned width);
    logic [31:0] x;
    x = v & width_mask(width);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

  // Legal Johnson states are a run of ones anchored at bit 0, or a run of
  // ones anchored at the MSB (i.e. the inverse is anchored at bit 0).
  function automatic logic is_johnson(input logic [31:0] v, input int unsigned width);
    logic [31:0] x;
    logic [31:0] y;
    x = v & width_mask(width);
    y = ~v & width_mask(width);
    return ((x & (x + 32'd1)) == 32'd0) || ((y & (y + 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running enable prescaler: tick is high once every 2**DIV_BITS enabled
// cycles, or permanently when DIV_BITS is 0.
module tick_prescaler #(
  parameter int DIV_BITS = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV_BITS > 0) ? DIV_BITS : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CW'(1);
  end

  assign tick = (DIV_BITS == 0) ? 1'b1 : &cnt;

endmodule

// File: rtl/mode_counter.sv
// Run-time selectable up/down/Johnson/ring counter with load, prescaled
// stepping and a registered terminal-count pulse.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [1:0]       mode_q
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic             tick;
  logic             clr;
  logic [WIDTH-1:0] count_d;
  logic [1:0]       mode_d;
  logic             tc_d;

  tick_prescaler #(.DIV_BITS(DIV_BITS)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      mode_q <= MODE_UP;
      tc     <= 1'b0;
    end else begin
      count  <= count_d;
      mode_q <= mode_d;
      tc     <= tc_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    count_d = count;
    mode_d  = mode_q;
    tc_d    = 1'b0;
    clr     = 1'b0;

    if (mode != mode_q) begin
      mode_d  = mode;
      count_d = WIDTH'(seed(mode, WIDTH));
      clr     = 1'b1;
    end else if (ld) begin
      clr = 1'b1;
      case (mode_q)
        MODE_RING:    count_d = is_onehot(32'(ld_val), WIDTH)  ? ld_val : WIDTH'(1);
        MODE_JOHNSON: count_d = is_johnson(32'(ld_val), WIDTH) ? ld_val : '0;
        default:      count_d = ld_val;
      endcase
    end else if (en && tick) begin
      case (mode_q)
        MODE_UP: begin
          count_d = count + WIDTH'(1);
          tc_d    = &count;
        end
        MODE_DOWN: begin
          count_d = count - WIDTH'(1);
          tc_d    = (count == '0);
        end
        MODE_JOHNSON: begin
          // Illegal states recover to the seed with no wrap report.
          if (is_johnson(32'(count), WIDTH)) begin
            count_d = {count[WIDTH-2:0], ~count[WIDTH-1]};
            tc_d    = (count == MSB_ONLY);
          end else begin
            count_d = '0;
          end
        end
        default: begin
          if (is_onehot(32'(count), WIDTH)) begin
            count_d = {count[WIDTH-2:0], count[WIDTH-1]};
            tc_d    = (count == MSB_ONLY);
          end else begin
            count_d = WIDTH'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: two instances (DIV_BITS 0 and 2) share
// stimulus; a per-instance reference model queues expected outputs.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst, en, ld;
  logic [1:0] mode;
  logic [3:0] ld_val;

  logic [3:0] count0, count1;
  logic       tc0, tc1;
  logic [1:0] mode_q0, mode_q1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] c0; logic t0; logic [1:0] m0;
    logic [3:0] c1; logic t1; logic [1:0] m1;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state per instance.
  logic [3:0] m_count [2];
  logic [1:0] m_mode  [2];
  logic       m_tc    [2];
  int         m_pre   [2];

  logic [3:0] jseq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .DIV_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ld(ld), .ld_val(ld_val),
    .count(count0), .tc(tc0), .mode_q(mode_q0)
  );

  mode_counter #(.WIDTH(4), .DIV_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ld(ld), .ld_val(ld_val),
    .count(count1), .tc(tc1), .mode_q(mode_q1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int jidx(input logic [3:0] v);
    for (int k = 0; k < 8; k++)
      if (jseq[k] == v) return k;
    return -1;
  endfunction

  task automatic model(input int i, input int div);
    int         period;
    logic       tick;
    logic [3:0] c;
    period = 1 << div;
    c      = m_count[i];
    m_tc[i] = 1'b0;
    if (rst) begin
      m_count[i] = 4'd0; m_mode[i] = 2'd0; m_pre[i] = 0;
    end else if (mode != m_mode[i]) begin
      m_mode[i] = mode; m_pre[i] = 0;
      case (mode)
        2'd1:    m_count[i] = 4'hF;
        2'd3:    m_count[i] = 4'h1;
        default: m_count[i] = 4'h0;
      endcase
    end else if (ld) begin
      m_pre[i] = 0;
      case (m_mode[i])
        2'd2:    m_count[i] = (jidx(ld_val) >= 0) ? ld_val : 4'h0;
        2'd3:    m_count[i] = ($countones(ld_val) == 1) ? ld_val : 4'h1;
        default: m_count[i] = ld_val;
      endcase
    end else if (en) begin
      tick = (m_pre[i] == period - 1);
      m_pre[i] = (m_pre[i] + 1) % period;
      if (tick) begin
        case (m_mode[i])
          2'd0: begin m_count[i] = c + 4'd1; m_tc[i] = (c == 4'hF); end
          2'd1: begin m_count[i] = c - 4'd1; m_tc[i] = (c == 4'h0); end
          2'd2: begin
            if (jidx(c) < 0) m_count[i] = 4'h0;
            else begin m_count[i] = jseq[(jidx(c) + 1) % 8]; m_tc[i] = (c == 4'h8); end
          end
          default: begin
            if ($countones(c) != 1) m_count[i] = 4'h1;
            else begin m_count[i] = {c[2:0], c[3]}; m_tc[i] = (c == 4'h8); end
          end
        endcase
      end
    end
  endtask

  // Drive one cycle at the falling edge, queue expectations, compare #1 after
  // the next rising edge.
  task automatic cyc(input logic r, input logic e, input logic [1:0] md,
                     input logic l, input logic [3:0] lv);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = md; ld = l; ld_val = lv;
    model(0, 0);
    model(1, 2);
    exp_q.push_back('{m_count[0], m_tc[0], m_mode[0], m_count[1], m_tc[1], m_mode[1]});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      check("count_div0", 32'(count0), 32'(x.c0));
      check("tc_div0",    32'(tc0),    32'(x.t0));
      check("mode_q_div0", 32'(mode_q0), 32'(x.m0));
      check("count_div2", 32'(count1), 32'(x.c1));
      check("tc_div2",    32'(tc1),    32'(x.t1));
      check("mode_q_div2", 32'(mode_q1), 32'(x.m1));
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; ld = 1'b0; ld_val = 4'd0;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 4'd0; m_mode[i] = 2'd0; m_tc[i] = 1'b0; m_pre[i] = 0;
    end

    // Reset state.
    cyc(1, 0, 2'd0, 0, 4'd0);
    cyc(1, 0, 2'd0, 0, 4'd0);
    check("reset_count", 32'(count0), 32'd0);

    // Up count through a wrap.
    for (int k = 0; k < 17; k++) cyc(0, 1, 2'd0, 0, 4'd0);
    check("up_after_17", 32'(count0), 32'd1);

    // Switch to down at count 5.
    cyc(1, 0, 2'd0, 0, 4'd0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 2'd0, 0, 4'd0);
    check("up_at_5", 32'(count0), 32'd5);
    cyc(0, 1, 2'd1, 0, 4'd0);
    check("down_seed", 32'(count0), 32'd15);
    check("down_seed_tc", 32'(tc0), 32'd0);
    for (int k = 0; k < 17; k++) cyc(0, 1, 2'd1, 0, 4'd0);

    // Johnson sequence, then illegal and legal loads.
    cyc(0, 1, 2'd2, 0, 4'd0);
    for (int k = 0; k < 9; k++) cyc(0, 1, 2'd2, 0, 4'd0);
    cyc(0, 1, 2'd2, 1, 4'b0101);
    check("johnson_bad_load", 32'(count0), 32'd0);
    cyc(0, 0, 2'd2, 1, 4'b1100);
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'd2, 0, 4'd0);

    // Ring: illegal load falls back to 0001, then rotate through a wrap.
    cyc(0, 1, 2'd3, 0, 4'd0);
    cyc(0, 1, 2'd3, 1, 4'b0110);
    check("ring_bad_load", 32'(count0), 32'd1);
    for (int k = 0; k < 4; k++) cyc(0, 1, 2'd3, 0, 4'd0);
    check("ring_wrap_tc", 32'(tc0), 32'd1);
    cyc(0, 1, 2'd3, 1, 4'b0100);
    for (int k = 0; k < 3; k++) cyc(0, 1, 2'd3, 0, 4'd0);

    // Prescaled stepping with an enable gap mid-period.
    cyc(1, 0, 2'd0, 0, 4'd0);
    for (int k = 0; k < 6; k++) cyc(0, 1, 2'd0, 0, 4'd0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 2'd0, 0, 4'd0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 2'd0, 0, 4'd0);
    check("div2_count", 32'(count1), 32'd4);

    // Reset overrides load, mode change and enable.
    cyc(1, 0, 2'd0, 0, 4'd0);
    for (int k = 0; k < 9; k++) cyc(0, 1, 2'd0, 0, 4'd0);
    cyc(1, 1, 2'd2, 1, 4'd7);
    check("rst_priority", 32'(count0), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 2'd0, 0, 4'd0);
    cyc(0, 1, 2'd0, 1, 4'd12);
    check("load_no_step", 32'(count0), 32'd12);

    // Randomised traffic.
    for (int k = 0; k < 300; k++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : mode,
          ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
